// File: rtl/dmem_arbiter_if.sv
// Signal bundle joining the two thread memory stages, the data-memory arbiter
// and the 64K x 16 data memory. The arbiter uses the slave view.
interface dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          halt;
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  halt, req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output halt, req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data-memory port between two
// hardware threads; one access in flight at a time, all outputs registered.
module dmem_arbiter #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_prio;
    logic          r_id;
    logic          r_we;
    logic [CW-1:0] r_cnt;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_busy;

    logic          w_win;
    logic          w_take;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // Winner selection: a lone requester wins, a tie goes to the favoured thread.
    always_comb begin
        w_win = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_win = r_prio;
        end else if (bus.req1) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
    end

    // Route the winning thread's access fields toward the latch.
    always_comb begin
        w_sel_we    = bus.we0;
        w_sel_addr  = bus.addr0;
        w_sel_wdata = bus.wdata0;
        if (w_win) begin
            w_sel_we    = bus.we1;
            w_sel_addr  = bus.addr1;
            w_sel_wdata = bus.wdata1;
        end else begin
            w_sel_we    = bus.we0;
            w_sel_addr  = bus.addr0;
            w_sel_wdata = bus.wdata0;
        end
    end

    assign w_take = (r_state == ST_IDLE) && !bus.halt && (bus.req0 || bus.req1);

    // Access sequencer: the registered outputs for the next state are loaded on
    // the transition into it, so the memory strobe and grant share the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_prio      <= 1'b0;
            r_id        <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata     <= {DW{1'b0}};
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {AW{1'b0}};
            r_mem_wdata <= {DW{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rvalid0 <= 1'b0;
                    r_rvalid1 <= 1'b0;
                    if (w_take) begin
                        r_id        <= w_win;
                        r_we        <= w_sel_we;
                        r_prio      <= ~w_win;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_gnt0      <= ~w_win;
                        r_gnt1      <= w_win;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_cnt    <= CW'(LAT - 1);
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == {CW{1'b0}}) begin
                        // mem_rdata is valid exactly in the last WAIT cycle.
                        if (!r_we) begin
                            r_rdata <= bus.mem_rdata;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                        r_rvalid0 <= ~r_id;
                        r_rvalid1 <= r_id;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt   <= r_cnt - CW'(1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    r_rvalid0 <= 1'b0;
                    r_rvalid1 <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_gnt0    <= 1'b0;
                    r_gnt1    <= 1'b0;
                    r_rvalid0 <= 1'b0;
                    r_rvalid1 <= 1'b0;
                    r_mem_en  <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
    assign bus.rdata     = r_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a transaction-level schedule model pushes
// expected issue/response events into a scoreboard that a monitor drains.
module tb_dmem_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    dmem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int unsigned   cyc;
        bit            resp;
        logic [1:0]    who;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           sb[$];
    int unsigned   cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    bit            m_prio = 1'b0;
    int unsigned   m_free = 0;
    int unsigned   b_lo = 1;
    int unsigned   b_hi = 0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] ref_mem [int];
    logic          drop0, drop1;

    // Data memory: words never written hold a fixed address-derived pattern.
    logic [DW-1:0] pmem [0:(1<<AW)-1];
    bit            pwr  [0:(1<<AW)-1];
    logic [DW-1:0] rpipe [LAT];

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [DW-1:0] phys_rd(input logic [AW-1:0] a);
        return pwr[a] ? pmem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            pmem[bus.mem_addr] <= bus.mem_wdata;
            pwr[bus.mem_addr]  <= 1'b1;
        end
        rpipe[0] <= (bus.mem_en && !bus.mem_we) ? phys_rd(bus.mem_addr) : DW'($urandom);
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.mem_rdata = rpipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata, bus.mem_en,
                    bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy});
    endfunction

    task automatic monitor_step();
        ev_t  e;
        logic exp_busy;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event cycle %0d: got nothing expected resp=%0d who=%b", e.cyc, e.resp, e.who);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (!e.resp)
                check("issue", 64'({bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                      64'({e.who, 2'b00, 1'b1, e.we, e.addr, e.data}));
            else
                check("resp", 64'({bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.mem_en, bus.rdata}),
                      64'({2'b00, e.who, 1'b0, e.data}));
        end else begin
            check("quiet", 64'({bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.mem_en}), 64'(0));
        end
        exp_busy = (cyc >= b_lo) && (cyc <= b_hi);
        check("busy", 64'(bus.busy), 64'(exp_busy));
    endtask

    // Schedule model: an accepted request at cycle c owns the port until c+LAT+2.
    task automatic model_step();
        ev_t           e;
        bit            w;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd;
        if (reset) begin
            while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
            m_prio  = 1'b0;
            m_free  = cyc + 1;
            m_rdata = '0;
            if (b_hi > cyc) b_hi = cyc;
        end else if (!bus.halt && cyc >= m_free && (bus.req0 || bus.req1)) begin
            w  = (bus.req0 && bus.req1) ? m_prio : bus.req1;
            we = w ? bus.we1 : bus.we0;
            a  = w ? bus.addr1 : bus.addr0;
            d  = w ? bus.wdata1 : bus.wdata0;
            e.cyc = cyc + 1; e.resp = 1'b0; e.who = w ? 2'b10 : 2'b01;
            e.we = we; e.addr = a; e.data = d;
            sb.push_back(e);
            if (we) begin
                ref_mem[int'(a)] = d;
                rd = m_rdata;
            end else begin
                rd = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
                m_rdata = rd;
            end
            e.cyc = cyc + 2 + LAT; e.resp = 1'b1; e.data = rd;
            sb.push_back(e);
            m_prio = ~w;
            m_free = cyc + 3 + LAT;
            b_lo   = cyc + 1;
            b_hi   = cyc + 2 + LAT;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drop0 = bus.gnt0 && bus.req0;
        drop1 = bus.gnt1 && bus.req1;
        if (bus.gnt0) bus.req0 = 1'b0;
        if (bus.gnt1) bus.req1 = 1'b0;
    endtask

    task automatic set_req(input int t, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (t == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic wait_quiet();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            done = (sb.size() == 0) && !bus.req0 && !bus.req1 && (cyc >= m_free);
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout cycle %0d: got %0d pending events expected 0", cyc, sb.size());
        end
    endtask

    // kind 0: rvalid0, 1: rvalid1, 2: gnt1
    task automatic wait_ev(input int kind, output int unsigned at);
        bit hit = 1'b0;
        at = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            hit = (kind == 0 && bus.rvalid0) || (kind == 1 && bus.rvalid1) || (kind == 2 && bus.gnt1);
            if (hit) at = cyc;
        end
        if (!hit) begin
            vectors++; miscompares++;
            $display("FAIL event_timeout cycle %0d: got no event kind %0d expected one", cyc, kind);
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h0010 + AW'($urandom_range(0, 7));
            default: return AW'($urandom);
        endcase
    endfunction

    initial begin
        int unsigned t0, at;
        reset = 1'b1;
        bus.halt = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_state", all_outs(), 64'(0));

        // Single load: data LAT+2 cycles after the req sample.
        set_req(0, 1'b0, 16'h0010, 16'h0000);
        t0 = cyc;
        wait_ev(0, at);
        check("load_latency", 64'(at - t0), 64'(LAT + 2));
        check("load_rdata", 64'(bus.rdata), 64'(16'hBEEF));
        wait_quiet();

        // Contention twice in a row: round-robin alternates the winner.
        set_req(0, 1'b0, 16'h0020, 16'h0000);
        set_req(1, 1'b0, 16'h0021, 16'h0000);
        wait_quiet();
        set_req(0, 1'b0, 16'h0022, 16'h0000);
        set_req(1, 1'b0, 16'h0023, 16'h0000);
        wait_quiet();

        // Store then load back.
        set_req(1, 1'b1, 16'h0100, 16'h1234);
        wait_quiet();
        set_req(0, 1'b0, 16'h0100, 16'h0000);
        wait_ev(0, at);
        check("store_readback", 64'(bus.rdata), 64'(16'h1234));
        wait_quiet();

        // Halt during an access: the access completes, the next grant waits.
        set_req(0, 1'b0, 16'h0010, 16'h0000);
        tick();
        tick();
        bus.halt = 1'b1;
        set_req(1, 1'b0, 16'h0011, 16'h0000);
        repeat (6) tick();
        bus.halt = 1'b0;
        t0 = cyc;
        wait_ev(2, at);
        check("halt_release_gnt", 64'(at - t0), 64'(1));
        wait_quiet();

        // Reset in the WAIT cycle drops the access.
        set_req(0, 1'b0, 16'h0030, 16'h0000);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_mid_access", all_outs(), 64'(0));
        set_req(0, 1'b0, 16'h0010, 16'h0000);
        t0 = cyc;
        wait_ev(0, at);
        check("post_reset_latency", 64'(at - t0), 64'(LAT + 2));
        check("post_reset_rdata", 64'(bus.rdata), 64'(16'hBEEF));
        wait_quiet();

        // Random traffic with sporadic halt and reset.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!bus.req0 && !drop0 && $urandom_range(0, 3) == 0)
                set_req(0, 1'($urandom_range(0, 1)), pick_addr(), DW'($urandom));
            if (!bus.req1 && !drop1 && $urandom_range(0, 3) == 0)
                set_req(1, 1'($urandom_range(0, 1)), pick_addr(), DW'($urandom));
            bus.halt = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 249) == 0);
        end
        bus.halt = 1'b0;
        reset    = 1'b0;
        wait_quiet();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
